f9pcap_axis_frame_chk: RTL and testbench

F9PCAP_AXIS_FRAME_CHK -- requirements
Module: f9pcap_axis_frame_chk

---
 rtl/f9pcap_axis_frame_chk.sv | 196 +++++++++++++++++++
 tb/tb_f9pcap_axis_frame_chk.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f9pcap_axis_frame_chk.sv
// f9pcap_axis_frame_chk: checks received AXIS test frames against a rolling byte pattern,
// tkeep shape and length rules, and keeps good/errored frame totals. Results are registered
// one cycle after the checked beat; no tready, the checker always accepts. Optional good-frame
// byte accumulator is built when F9PCAP_FRAME_CHK_BYTECNT_EN is defined.
module f9pcap_axis_frame_chk #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_LEN    = 32,
  parameter int MAX_LEN    = 1514,
  parameter int LEN_SWEEP  = 1
) (
  input  logic                  rx_axis_clk,
  input  logic                  rx_axis_rst,
  input  logic                  rx_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic                  rx_axis_tlast,
  input  logic                  rx_axis_tuser,
  input  logic                  clear,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           err_cnt,
  output logic [2:0]            last_err,
  output logic                  err_pulse,
  output logic                  in_frame,
  output logic [15:0]           exp_len,
  output logic [47:0]           rx_byte_cnt
);

  // Running length needs one bit of headroom above 16 bits so an over-length beat is visible.
  localparam int LW = 17;
  localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [15:0]   MIN_E = 16'(MIN_LEN);
  localparam logic [15:0]   MAX_E = 16'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_t;

  state_t          state_q;
  logic [LW-1:0]   len_q;
  logic [15:0]     seq_q;
  logic [15:0]     exp_len_q;
  logic [31:0]     frame_cnt_q;
  logic [31:0]     err_cnt_q;
  logic [2:0]      last_err_q;
  logic            err_pulse_q;
  logic            in_frame_q;

  logic [LW-1:0]   off;
  logic [LW-1:0]   nbytes;
  logic [LW-1:0]   new_len;
  logic            data_bad;
  logic            keep_bad;
  logic            len_over;
  logic            len_bad;
  logic            user_bad;
  logic [2:0]      err_code;
  logic            check_en;
  logic            err_hit;
  logic            frame_end;
  logic            good_end;

  // Per-beat checks: pattern, tkeep shape, length, tuser; resolve to one prioritised code.
  always_comb begin
    off      = (state_q == ST_IDLE) ? '0 : len_q;
    nbytes   = '0;
    data_bad = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      nbytes = nbytes + LW'(rx_axis_tkeep[i]);
      if (rx_axis_tkeep[i] &&
          (rx_axis_tdata[8*i +: 8] != 8'(off[7:0] + 8'(i) + seq_q[7:0]))) begin
        data_bad = 1'b1;
      end
    end
    new_len = off + nbytes;
    if (rx_axis_tlast) begin
      keep_bad = (rx_axis_tkeep == '0) ||
                 ((rx_axis_tkeep & (rx_axis_tkeep + KEEP_WIDTH'(1))) != '0);
    end else begin
      keep_bad = (rx_axis_tkeep != '1);
    end
    len_over = (new_len > MAX_L);
    len_bad  = rx_axis_tlast &&
               ((new_len < MIN_L) || ((LEN_SWEEP != 0) && (new_len != {1'b0, exp_len_q})));
    user_bad = rx_axis_tlast && rx_axis_tuser;
    if (len_over)      err_code = 3'd5;
    else if (user_bad) err_code = 3'd4;
    else if (keep_bad) err_code = 3'd2;
    else if (len_bad)  err_code = 3'd3;
    else if (data_bad) err_code = 3'd1;
    else               err_code = 3'd0;

    // Beats seen in DROP are only watched for tlast; clear overrides any result this cycle.
    check_en  = rx_axis_tvalid && (state_q != ST_DROP) && !clear;
    err_hit   = check_en && (err_code != 3'd0);
    frame_end = rx_axis_tvalid && rx_axis_tlast && !clear;
    good_end  = check_en && rx_axis_tlast && (err_code == 3'd0);
  end

  // Frame FSM with counters, sequence and expected length; all outputs registered here.
  always_ff @(posedge rx_axis_clk or posedge rx_axis_rst) begin
    if (rx_axis_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      seq_q       <= '0;
      exp_len_q   <= MIN_E;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      last_err_q  <= '0;
      err_pulse_q <= 1'b0;
      in_frame_q  <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (clear) begin
        state_q     <= ST_IDLE;
        len_q       <= '0;
        seq_q       <= '0;
        exp_len_q   <= MIN_E;
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
        last_err_q  <= '0;
        in_frame_q  <= 1'b0;
      end else begin
        if (err_hit) begin
          if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
          last_err_q  <= err_code;
          err_pulse_q <= 1'b1;
        end
        if (good_end && (frame_cnt_q != 32'hFFFF_FFFF)) begin
          frame_cnt_q <= frame_cnt_q + 32'd1;
        end
        if (frame_end) begin
          seq_q <= seq_q + 16'd1;
          if (LEN_SWEEP != 0) begin
            exp_len_q <= (exp_len_q == MAX_E) ? MIN_E : exp_len_q + 16'd1;
          end
        end
        if (rx_axis_tvalid) begin
          unique case (state_q)
            ST_IDLE, ST_DATA: begin
              if (rx_axis_tlast) begin
                state_q    <= ST_IDLE;
                in_frame_q <= 1'b0;
              end else if (err_code != 3'd0) begin
                state_q    <= ST_DROP;
                in_frame_q <= 1'b1;
              end else begin
                state_q    <= ST_DATA;
                in_frame_q <= 1'b1;
                len_q      <= new_len;
              end
            end
            ST_DROP: begin
              if (rx_axis_tlast) begin
                state_q    <= ST_IDLE;
                in_frame_q <= 1'b0;
              end
            end
            default: begin
              state_q    <= ST_IDLE;
              in_frame_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign last_err  = last_err_q;
  assign err_pulse = err_pulse_q;
  assign in_frame  = in_frame_q;
  assign exp_len   = exp_len_q;

`ifdef F9PCAP_FRAME_CHK_BYTECNT_EN
  logic [47:0] byte_cnt_q;
  logic [48:0] byte_sum;
  assign byte_sum = {1'b0, byte_cnt_q} + 49'(new_len);

  // Accumulate lengths of good frames, saturating at all ones.
  always_ff @(posedge rx_axis_clk or posedge rx_axis_rst) begin
    if (rx_axis_rst) begin
      byte_cnt_q <= '0;
    end else if (clear) begin
      byte_cnt_q <= '0;
    end else if (good_end) begin
      byte_cnt_q <= byte_sum[48] ? '1 : byte_sum[47:0];
    end
  end

  assign rx_byte_cnt = byte_cnt_q;
`else
  assign rx_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_f9pcap_axis_frame_chk.sv
// tb_f9pcap_axis_frame_chk: directed frame vectors for the AXIS frame checker.
module tb_f9pcap_axis_frame_chk;

`ifdef F9PCAP_FRAME_CHK_BYTECNT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        tvalid, tlast, tuser;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  logic [31:0] frame_cnt, err_cnt;
  logic [2:0]  last_err;
  logic        err_pulse, in_frame;
  logic [15:0] exp_len;
  logic [47:0] byte_cnt;

  logic [31:0] n_frame_cnt, n_err_cnt;
  logic [2:0]  n_last_err;
  logic        n_err_pulse, n_in_frame;
  logic [15:0] n_exp_len;
  logic [47:0] n_byte_cnt;

  logic         w_tvalid, w_tlast;
  logic [255:0] w_tdata;
  logic [31:0]  w_tkeep;
  logic [31:0]  w_frame_cnt, w_err_cnt;
  logic [2:0]   w_last_err;
  logic         w_err_pulse, w_in_frame;
  logic [15:0]  w_exp_len;
  logic [47:0]  w_byte_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int bseq  = 0;
  int wseq  = 0;

  always #5 clk = ~clk;

  f9pcap_axis_frame_chk u_dut (
    .rx_axis_clk(clk), .rx_axis_rst(rst), .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata),
    .rx_axis_tkeep(tkeep), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .clear(clear),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .last_err(last_err), .err_pulse(err_pulse),
    .in_frame(in_frame), .exp_len(exp_len), .rx_byte_cnt(byte_cnt)
  );

  f9pcap_axis_frame_chk #(.LEN_SWEEP(0)) u_ns (
    .rx_axis_clk(clk), .rx_axis_rst(rst), .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata),
    .rx_axis_tkeep(tkeep), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .clear(clear),
    .frame_cnt(n_frame_cnt), .err_cnt(n_err_cnt), .last_err(n_last_err), .err_pulse(n_err_pulse),
    .in_frame(n_in_frame), .exp_len(n_exp_len), .rx_byte_cnt(n_byte_cnt)
  );

  f9pcap_axis_frame_chk #(.DATA_WIDTH(256), .MIN_LEN(32), .MAX_LEN(34)) u_w (
    .rx_axis_clk(clk), .rx_axis_rst(rst), .rx_axis_tvalid(w_tvalid), .rx_axis_tdata(w_tdata),
    .rx_axis_tkeep(w_tkeep), .rx_axis_tlast(w_tlast), .rx_axis_tuser(1'b0), .clear(clear),
    .frame_cnt(w_frame_cnt), .err_cnt(w_err_cnt), .last_err(w_last_err), .err_pulse(w_err_pulse),
    .in_frame(w_in_frame), .exp_len(w_exp_len), .rx_byte_cnt(w_byte_cnt)
  );

  typedef struct {
    int         len;
    int         bad;
    logic [7:0] lkeep;
    logic       usr;
    logic       gap;
    logic       clr;
    int         e_frames;
    int         e_errs;
    int         e_le;
    int         e_exp;
    int         e_pulses;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame on the 64-bit bus; pattern byte k = k + seq. Optional corrupted byte,
  // overridden last tkeep, tuser, idle gap between beats and clear on the tlast beat.
  task automatic send_frame(input int len, input int bad, input logic [7:0] lkeep,
                            input logic usr, input logic gap, input logic clr_last,
                            output int pulses, output int first_pulse, output int inf_bad);
    int nb;
    nb = (len + 7) / 8;
    pulses = 0;
    first_pulse = -1;
    inf_bad = 0;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      int          rem;
      logic        lst;
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = b * 8 + i;
        d[8*i +: 8] = 8'((idx + bseq) & 255);
        if (idx == bad) d[8*i +: 8] ^= 8'hFF;
      end
      lst = (b == nb - 1);
      rem = len - b * 8;
      if (!lst)              k = 8'hFF;
      else if (lkeep != 8'h00) k = lkeep;
      else if (rem >= 8)     k = 8'hFF;
      else                   k = 8'((1 << rem) - 1);
      tvalid = 1'b1; tdata = d; tkeep = k; tlast = lst;
      tuser  = lst & usr;
      clear  = lst & clr_last;
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; clear = 1'b0;
      if (err_pulse) begin
        pulses++;
        if (first_pulse < 0) first_pulse = b;
      end
      if (!lst && !in_frame) inf_bad++;
      if (lst && in_frame)   inf_bad++;
      if (gap && !lst) begin
        @(posedge clk); #1;
      end
    end
    bseq = clr_last ? 0 : ((bseq + 1) & 16'hFFFF);
  endtask

  task automatic send256(input int len);
    int nb;
    nb = (len + 31) / 32;
    for (int b = 0; b < nb; b++) begin
      logic [255:0] d;
      logic [31:0]  k;
      int           rem;
      rem = len - b * 32;
      for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'((b * 32 + i + wseq) & 255);
      k = '1;
      if (rem < 32) k = (32'd1 << rem) - 32'd1;
      w_tvalid = 1'b1; w_tdata = d; w_tkeep = k; w_tlast = (b == nb - 1);
      @(posedge clk); #1;
      w_tvalid = 1'b0; w_tlast = 1'b0;
    end
    wseq++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bseq = 0;
  endtask

  initial begin
    int     pulses, fp, inf, fp2000;
    longint bytes;
    int     wlens[4];
    int     wexp[4];

    for (int i = 0; i < 9; i++)
      vecs[i] = '{len:32+i, bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0,
                  e_frames:i+1, e_errs:0, e_le:0, e_exp:33+i, e_pulses:0};
    vecs[9]  = '{len:32,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b1, e_frames:1, e_errs:0, e_le:0, e_exp:33, e_pulses:0};
    vecs[10] = '{len:33,   bad:5,  lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:1, e_errs:1, e_le:1, e_exp:34, e_pulses:1};
    vecs[11] = '{len:34,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:2, e_errs:1, e_le:1, e_exp:35, e_pulses:0};
    vecs[12] = '{len:33,   bad:-1, lkeep:8'h05, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:2, e_errs:2, e_le:2, e_exp:36, e_pulses:1};
    vecs[13] = '{len:36,   bad:-1, lkeep:8'h00, usr:1'b1, gap:1'b0, clr:1'b0, e_frames:2, e_errs:3, e_le:4, e_exp:37, e_pulses:1};
    vecs[14] = '{len:37,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:3, e_errs:3, e_le:4, e_exp:38, e_pulses:0};
    vecs[15] = '{len:30,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:3, e_errs:4, e_le:3, e_exp:39, e_pulses:1};
    vecs[16] = '{len:40,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:3, e_errs:5, e_le:3, e_exp:40, e_pulses:1};
    vecs[17] = '{len:40,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b1, clr:1'b0, e_frames:4, e_errs:5, e_le:3, e_exp:41, e_pulses:0};
    vecs[18] = '{len:2000, bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:4, e_errs:6, e_le:5, e_exp:42, e_pulses:1};
    vecs[19] = '{len:42,   bad:-1, lkeep:8'h00, usr:1'b0, gap:1'b0, clr:1'b0, e_frames:5, e_errs:6, e_le:5, e_exp:43, e_pulses:0};
    vecs[20] = '{len:38,   bad:-1, lkeep:8'h00, usr:1'b1, gap:1'b0, clr:1'b0, e_frames:5, e_errs:7, e_le:4, e_exp:44, e_pulses:1};
    wlens = '{32, 33, 34, 32};
    wexp  = '{33, 34, 32, 33};

    rst = 1'b1; clear = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; tkeep = '0;
    w_tvalid = 1'b0; w_tlast = 1'b0; w_tdata = '0; w_tkeep = '0;
    fp2000 = -1;
    bytes = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst last_err", last_err, 0);
    chk("rst err_pulse", err_pulse, 0);
    chk("rst in_frame", in_frame, 0);
    chk("rst exp_len", exp_len, 32);
    chk("rst byte_cnt", byte_cnt, 0);

    // 256-bit bus, short sweep window 32..34 wrapping back to 32
    for (int i = 0; i < 4; i++) begin
      send256(wlens[i]);
      chk($sformatf("w%0d frame_cnt", i), w_frame_cnt, i + 1);
      chk($sformatf("w%0d err_cnt", i), w_err_cnt, 0);
      chk($sformatf("w%0d exp_len", i), w_exp_len, wexp[i]);
    end

    // Table of frames on the 64-bit bus
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].clr) begin
        do_clear();
        bytes = 0;
      end
      send_frame(vecs[i].len, vecs[i].bad, vecs[i].lkeep, vecs[i].usr, vecs[i].gap, 1'b0,
                 pulses, fp, inf);
      if (vecs[i].e_pulses == 0) bytes += vecs[i].len;
      if (i == 18) fp2000 = fp;
      chk($sformatf("v%0d frame_cnt", i), frame_cnt, vecs[i].e_frames);
      chk($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].e_errs);
      chk($sformatf("v%0d last_err", i), last_err, vecs[i].e_le);
      chk($sformatf("v%0d exp_len", i), exp_len, vecs[i].e_exp);
      chk($sformatf("v%0d err_pulses", i), pulses, vecs[i].e_pulses);
      chk($sformatf("v%0d in_frame", i), inf, 0);
      chk($sformatf("v%0d byte_cnt", i), byte_cnt, BC ? bytes : 0);
    end
    // Over-length error appears on beat index 189 (bytes 1512..1519)
    chk("overlen beat", fp2000, 189);

    // Reset in the middle of a frame
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) tdata[8*i +: 8] = 8'((b * 8 + i + bseq) & 255);
      tvalid = 1'b1; tkeep = 8'hFF; tlast = 1'b0;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    chk("mid in_frame", in_frame, 1);
    rst = 1'b1;
    #2;
    chk("mid rst frame_cnt", frame_cnt, 0);
    chk("mid rst err_cnt", err_cnt, 0);
    chk("mid rst last_err", last_err, 0);
    chk("mid rst in_frame", in_frame, 0);
    chk("mid rst exp_len", exp_len, 32);
    chk("mid rst byte_cnt", byte_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bseq = 0;
    send_frame(32, -1, 8'h00, 1'b0, 1'b0, 1'b0, pulses, fp, inf);
    chk("post rst frame_cnt", frame_cnt, 1);
    chk("post rst err_cnt", err_cnt, 0);
    chk("post rst pulses", pulses, 0);

    // clear on the tlast beat discards the frame result
    send_frame(33, -1, 8'h00, 1'b0, 1'b0, 1'b1, pulses, fp, inf);
    chk("clr tlast frame_cnt", frame_cnt, 0);
    chk("clr tlast err_cnt", err_cnt, 0);
    chk("clr tlast exp_len", exp_len, 32);
    chk("clr tlast pulses", pulses, 0);
    send_frame(32, -1, 8'h00, 1'b0, 1'b0, 1'b0, pulses, fp, inf);
    chk("after clr frame_cnt", frame_cnt, 1);
    chk("after clr exp_len", exp_len, 33);

    // Fixed 64-byte frames: accepted without sweep, length errors with sweep
    do_clear();
    for (int i = 0; i < 3; i++) send_frame(64, -1, 8'h00, 1'b0, 1'b0, 1'b0, pulses, fp, inf);
    chk("ns frame_cnt", n_frame_cnt, 3);
    chk("ns err_cnt", n_err_cnt, 0);
    chk("ns exp_len", n_exp_len, 32);
    chk("ns byte_cnt", n_byte_cnt, BC ? 192 : 0);
    chk("sw64 err_cnt", err_cnt, 3);
    chk("sw64 last_err", last_err, 3);
    chk("sw64 frame_cnt", frame_cnt, 0);
    chk("sw64 byte_cnt", byte_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
